fetch_unit: RTL and testbench

//  Instruction fetch stage ahead of the decoder. Owns the PC, issues reads to instruction memory, and buffers

---
 rtl/fetch_pkg.sv | 36 +++
 rtl/fetch_buffer.sv | 72 +++++++
 rtl/fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_fetch_unit.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared types and default sizes for the instruction fetch stage.
//   fetch_state_e : fetch FSM states (IDLE, RUN, REDIR)
//   branch_e      : branch field encoding from execute (11 is reserved = none)
//   ADDR_W_DEF    : default PC width (PC is a word index)
//   DEPTH_DEF     : default fetch buffer depth (power of 2, >= 2)
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam int unsigned ADDR_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 2;
    localparam int unsigned INST_W     = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        REDIR = 2'b10
    } fetch_state_e;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_EQ   = 2'b01,
        BR_LT   = 2'b10
    } branch_e;

    // Branch target modulo 2^ADDR_W; offset 0 yields the branch's own PC.
    function automatic logic [31:0] branch_target(input logic [31:0] pc,
                                                  input logic        dir,
                                                  input logic [4:0]  offset);
        logic [31:0] off_ext;
        off_ext = {27'd0, offset};
        return dir ? (pc - off_ext) : (pc + off_ext);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// ----------------------------------------------------------------------------
// fetch_buffer
// Synchronous FIFO holding fetched {pc, instruction} entries.
//   clk, rst  : clock, asynchronous active-high reset
//   push/wdata: write an entry at the tail (ignored when full)
//   pop       : consume the head entry (ignored when empty)
//   flush     : drop every entry; takes priority over push and pop
//   rdata     : head entry (only meaningful when !empty)
//   count     : number of stored entries
//   full/empty: occupancy flags
// ----------------------------------------------------------------------------
module fetch_buffer #(
    parameter int unsigned WIDTH = 40,
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    input  logic                       flush,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        empty   = (count_q == '0);
        full    = (count_q == (PTR_W + 1)'(DEPTH));
        do_push = push & ~full & ~flush;
        do_pop  = pop & ~empty & ~flush;
        count   = count_q;
        rdata   = mem_q[rd_ptr_q];
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the read side is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/fetch_unit.sv
// ----------------------------------------------------------------------------
// fetch_unit
// Instruction fetch stage: owns the PC, issues instruction memory reads,
// buffers returned words and hands them to decode over valid/ready.
// Taken beq/blt branches from execute redirect the PC and flush the buffer.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   run                 fetch enable (buffer still drains when low)
//   imem_req/imem_addr  read request and word address (= pc)
//   imem_rdata          read data, one cycle after imem_req
//   inst_valid/ready    handshake toward decode; inst/inst_pc payload
//   br_valid, br_pc     branch being resolved by execute and its PC
//   branch              00 none, 01 beq, 10 blt, 11 none
//   branch_dir/offset   target = br_pc -/+ offset (word units)
//   alu_zero, alu_neg   execute compare flags
//   redirect            registered pulse, one cycle after a taken branch
//   stall_cnt/redir_cnt optional saturating counters (FETCH_PERF_CNT_EN)
//
// Build option: define FETCH_PERF_CNT_EN to add stall_cnt and redir_cnt.
// ----------------------------------------------------------------------------
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [31:0]       imem_rdata,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    input  logic              br_valid,
    input  logic [ADDR_W-1:0] br_pc,
    input  logic [1:0]        branch,
    input  logic              branch_dir,
    input  logic [4:0]        branch_offset,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              redirect
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       redir_cnt
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = ADDR_W + INST_W;

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              inflight_q;
    logic [ADDR_W-1:0] inflight_pc_q;
    logic              redirect_q;

    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [31:0]       target_full;
    logic [CNT_W-1:0]  buf_count;
    logic [CNT_W:0]    occupancy;
    logic              buf_full;
    logic              buf_empty;
    logic              buf_push;
    logic              buf_pop;
    logic [ENT_W-1:0]  buf_rdata;

    // Branch resolution and target computation.
    always_comb begin
        taken = br_valid & (((branch == BR_EQ) & alu_zero) | ((branch == BR_LT) & alu_neg));
        target_full = branch_target(32'(br_pc), branch_dir, branch_offset);
        target      = target_full[ADDR_W-1:0];
    end

    // Issue only while the buffer can absorb every outstanding response.
    always_comb begin
        occupancy = {1'b0, buf_count} + {{CNT_W{1'b0}}, inflight_q};
        imem_req  = (state_q == RUN) & ~taken & (occupancy < (CNT_W + 1)'(DEPTH));
        imem_addr = pc_q;
    end

    // Next-state logic; a taken branch overrides everything.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (run) state_d = RUN;
            RUN:     if (!run) state_d = IDLE;
            REDIR:   state_d = run ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
        if (taken) state_d = REDIR;

        pc_d = pc_q;
        if (taken) begin
            pc_d = target;
        end else if (imem_req) begin
            pc_d = pc_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            redirect_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inflight_q <= imem_req;
            if (imem_req) inflight_pc_q <= pc_q;
            redirect_q <= taken;
        end
    end

    // A response arriving in the cycle a branch is taken belongs to the old
    // path, so it is dropped along with the flushed buffer.
    always_comb begin
        buf_push = inflight_q & ~taken & ~buf_full;
        buf_pop  = ~buf_empty & inst_ready;
    end

    fetch_buffer #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fetch_buffer (
        .clk   (clk),
        .rst   (rst),
        .push  (buf_push),
        .wdata ({inflight_pc_q, imem_rdata}),
        .pop   (buf_pop),
        .flush (taken),
        .rdata (buf_rdata),
        .count (buf_count),
        .full  (buf_full),
        .empty (buf_empty)
    );

    // Payload is forced to zero when nothing is valid.
    always_comb begin
        inst_valid = ~buf_empty;
        inst       = buf_empty ? '0 : buf_rdata[INST_W-1:0];
        inst_pc    = buf_empty ? '0 : buf_rdata[ENT_W-1:INST_W];
        redirect   = redirect_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt_q;
    logic [15:0] redir_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            redir_cnt_q <= '0;
        end else begin
            if (inst_valid & ~inst_ready & (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
            if (taken & (redir_cnt_q != 16'hFFFF)) begin
                redir_cnt_q <= redir_cnt_q + 16'd1;
            end
        end
    end

    always_comb begin
        stall_cnt = stall_cnt_q;
        redir_cnt = redir_cnt_q;
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_unit
// Self-checking bench for fetch_unit (ADDR_W=8, DEPTH=2). A behavioural model
// built from a queue of fetched PCs predicts every cycle's outputs; directed
// sequences are followed by randomized run/ready/branch stimulus.
// ----------------------------------------------------------------------------
module tb_fetch_unit;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst;
    logic        run;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [7:0]  inst_pc;
    logic        br_valid;
    logic [7:0]  br_pc;
    logic [1:0]  branch;
    logic        branch_dir;
    logic [4:0]  branch_offset;
    logic        alu_zero;
    logic        alu_neg;
    logic        redirect;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] redir_cnt;
`endif

    fetch_unit #(
        .ADDR_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .run           (run),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .inst_valid    (inst_valid),
        .inst_ready    (inst_ready),
        .inst          (inst),
        .inst_pc       (inst_pc),
        .br_valid      (br_valid),
        .br_pc         (br_pc),
        .branch        (branch),
        .branch_dir    (branch_dir),
        .branch_offset (branch_offset),
        .alu_zero      (alu_zero),
        .alu_neg       (alu_neg),
        .redirect      (redirect)
`ifdef FETCH_PERF_CNT_EN
        ,
        .stall_cnt     (stall_cnt),
        .redir_cnt     (redir_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [7:0] a);
        logic [7:0] b;
        b = a + 8'd1;
        return {a, ~a, a ^ 8'h5A, b};
    endfunction

    // Instruction memory: one-cycle read latency.
    always @(posedge clk) begin
        if (imem_req) imem_rdata <= mem_word(imem_addr);
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: 0 = stopped, 1 = fetching, 2 = redirect bubble.
    int         m_mode;
    logic [7:0] m_pc;
    logic [7:0] m_q[$];
    logic       m_fly;
    logic [7:0] m_fly_pc;
    logic       m_redir;

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = 8'd0;
        m_q.delete();
        m_fly   = 1'b0;
        m_fly_pc = 8'd0;
        m_redir = 1'b0;
    endtask

    task automatic step(input logic r, input logic rdy, input logic bv, input logic [7:0] bpc,
                        input logic [1:0] br, input logic d, input logic [4:0] off,
                        input logic z, input logic ng);
        logic       tk;
        logic [7:0] tgt;
        logic       req;
        logic       vld;
        run = r; inst_ready = rdy; br_valid = bv; br_pc = bpc; branch = br;
        branch_dir = d; branch_offset = off; alu_zero = z; alu_neg = ng;

        tk  = bv & (((br == 2'b01) & z) | ((br == 2'b10) & ng));
        tgt = d ? (bpc - 8'(off)) : (bpc + 8'(off));
        req = (m_mode == 1) && !tk && ((m_q.size() + int'(m_fly)) < DEPTH);
        vld = (m_q.size() > 0);

        @(negedge clk);
        check("imem_req", 32'(imem_req), 32'(req));
        check("imem_addr", 32'(imem_addr), 32'(m_pc));
        check("inst_valid", 32'(inst_valid), 32'(vld));
        check("inst_pc", 32'(inst_pc), vld ? 32'(m_q[0]) : 32'd0);
        check("inst", inst, vld ? mem_word(m_q[0]) : 32'd0);
        check("redirect", 32'(redirect), 32'(m_redir));

        @(posedge clk);
        if (tk) begin
            m_q.delete();
        end else begin
            if (vld && rdy) void'(m_q.pop_front());
            if (m_fly) m_q.push_back(m_fly_pc);
        end
        m_fly    = req;
        m_fly_pc = m_pc;
        m_pc     = tk ? tgt : (req ? m_pc + 8'd1 : m_pc);
        m_redir  = tk;
        if (tk)       m_mode = 2;
        else          m_mode = r ? 1 : 0;
        #1;
    endtask

    task automatic idle_steps(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b1, rdy, 1'b0, 8'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"}, 32'(imem_req), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_valid"}, 32'(inst_valid), 32'd0);
        check({tag, "_inst"}, inst, 32'd0);
        check({tag, "_pc"}, 32'(inst_pc), 32'd0);
        check({tag, "_redirect"}, 32'(redirect), 32'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; inst_ready = 1'b0; br_valid = 1'b0; br_pc = 8'd0;
        branch = 2'b00; branch_dir = 1'b0; branch_offset = 5'd0; alu_zero = 1'b0;
        alu_neg = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;

        // Straight-line fetch, then a decode stall and resume.
        idle_steps(20, 1'b1);
        idle_steps(5, 1'b0);
        idle_steps(10, 1'b1);

        // beq at pc 6, backward 4, taken.
        step(1'b1, 1'b1, 1'b1, 8'd6, 2'b01, 1'b1, 5'd4, 1'b1, 1'b0);
        idle_steps(8, 1'b1);
        // blt at pc 3 not taken, then taken forward 5.
        step(1'b1, 1'b1, 1'b1, 8'd3, 2'b10, 1'b0, 5'd5, 1'b1, 1'b0);
        idle_steps(4, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd3, 2'b10, 1'b0, 5'd5, 1'b0, 1'b1);
        idle_steps(6, 1'b1);
        // Reserved branch code never redirects; offset 0 is a self loop.
        step(1'b1, 1'b1, 1'b1, 8'd9, 2'b11, 1'b0, 5'd2, 1'b1, 1'b1);
        step(1'b1, 1'b1, 1'b1, 8'd9, 2'b01, 1'b0, 5'd0, 1'b1, 1'b0);
        idle_steps(6, 1'b1);
        // Backward 3 from pc 1 wraps to 254, then fetch across 255 -> 0.
        step(1'b1, 1'b1, 1'b1, 8'd1, 2'b01, 1'b1, 5'd3, 1'b1, 1'b0);
        idle_steps(14, 1'b1);
        // run low: issue stops, buffer drains.
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0, 8'd0, 2'b00, 1'b0, 5'd0, 1'b0, 1'b0);
        idle_steps(6, 1'b1);

        // Reset asserted while a request is in flight.
        for (int i = 0; i < 10 && !m_fly; i++) idle_steps(1, 1'b1);
        check("inflight_before_reset", 32'(m_fly), 32'd1);
        rst = 1'b1;
        #1;
        check_zero_outputs("midreset");
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_steps(8, 1'b1);

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 6) == 0, 8'($urandom), 2'($urandom),
                 1'($urandom), 5'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
